mac_serial: RTL and testbench
=============================

# mac_serial

Serial fixed-point multiply-accumulate stage for the ANN neuron datapath. It accepts a stream of (input, weight) pairs and computes their dot product over N terms. It then presents the signed sum through a valid/ready handshake. Its output feeds the downstream 2-input adder, where the bias is added before activation.

## Interface
- WIDTH, 32: data width of operands, products and sum (signed two's complement).
- FRAC, 24: fractional bits of the fixed-point format (Q(WIDTH-FRAC).FRAC).
- N, 4: terms per dot product (N ≥ 1).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- i_valid  input  1  input term present.
- o_ready  output  1  block accepts a term this cycle.
- i_x  input  WIDTH  signed neuron input.
- i_w  input  WIDTH  signed weight.
- i_clr  input  1  synchronous abort: discard the partial sum and restart.
- o_valid  output  1  dot product available.
- i_ready  input  1  downstream accepts the result.
- o_sum  output  WIDTH  signed dot product.
- o_sat  output  1  saturation occurred in this dot product (qualified by o_valid).

## Operation
- FSM with two states.
  - S_ACC: o_ready=1, o_valid=0.
  - S_OUT: o_ready=0, o_valid=1.
- Term accepted when i_valid && o_ready.
- Product: full 2·WIDTH signed product i_x·i_w, arithmetic right shift by FRAC (truncation toward −∞), then saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Accumulate: acc ← sat(acc + prod), computed at WIDTH+1 bits and saturated to the same range.
- Any product or accumulate saturation sets a sticky sat flag.
- Term counter cnt runs 0..N−1. On the accepted term with cnt==N−1: acc updates, cnt←0, state→S_OUT.
- S_OUT:
  - o_sum=acc and o_sat=sat, both held stable until i_ready.
  - On o_valid && i_ready: acc←0, sat←0, state→S_ACC.
- i_clr, valid in S_ACC only: acc←0, sat←0, cnt←0. i_clr wins over a simultaneous term accept. i_clr is ignored in S_OUT.
- i_valid, i_x and i_w are don't-care when o_ready=0.
- Reset, asynchronous and at any time including mid-dot-product or in S_OUT: state=S_ACC, acc=0, cnt=0, sat=0. Outputs after reset: o_ready=1, o_valid=0, o_sum=0, o_sat=0.
- Synchronous i_clr and rst asserted together: rst dominates.

## Timing
- One term per cycle maximum. Gaps in i_valid are allowed and do not affect the result.
- Latency: o_valid rises the cycle after the Nth term is accepted.
- o_sum and o_sat are registered, with no combinational path from inputs.
- Output handshake completes in the cycle where o_valid && i_ready. o_ready returns high the following cycle.
- Throughput at full rate: N+1 cycles per dot product.
- o_ready and o_valid are decoded directly from the state register. They are never both high and never both low out of reset.
- N=1: every accepted term goes directly to S_OUT.

## Structure
- Shared package/header holds:
  - default WIDTH and FRAC;
  - the saturation constants MAX = 2^(WIDTH−1)−1 and MIN = −2^(WIDTH−1);
  - the FSM state encoding (S_ACC=0, S_OUT=1).
- One sub-module: mult_fixed (combinational WIDTH×WIDTH signed multiply, shift by FRAC, saturate, overflow flag out). It is reused later by the backprop weight-update path.
- The accumulate adder with saturation stays inline; the FSM, counter and registers stay in mac_serial.

## Test plan
Values below use WIDTH=32, FRAC=24, N=4; 1.0 = 0x0100_0000.
- Basic: terms (1.0,2.0), (0.5,0.5), (−1.0,1.0), (0,5.0) back-to-back -> o_valid the cycle after the 4th term, o_sum=0x0140_0000 (1.25), o_sat=0.
- Saturation: four terms (127.0,1.0) i.e. i_x=0x7F00_0000, i_w=0x0100_0000 -> o_sum=0x7FFF_FFFF, o_sat=1. Repeat with i_x=0x8000_0000 -> o_sum=0x8000_0000, o_sat=1.
- Backpressure: hold i_ready=0 for 3 cycles after o_valid while driving i_valid=1 with junk -> o_sum and o_sat stable, o_ready=0, junk not accumulated. Release -> o_ready=1 next cycle, and the next dot product of four (1.0,1.0) gives 0x0400_0000.
- Bubbles: the basic terms with i_valid low for 2 cycles between each -> same 0x0140_0000. o_valid rises exactly one cycle after the last accepted term.
- Reset mid-operation: accept 2 terms of (1.0,1.0), assert rst asynchronously between edges -> o_ready=1, o_valid=0, o_sum=0 immediately. Then four terms (0.25,1.0) -> o_sum=0x0100_0000.
- Abort: accept 3 terms (1.0,1.0), then i_clr together with a valid term -> term discarded, cnt=0. Four terms (2.0,1.0) then give 0x0800_0000, o_sat=0.

Source files
------------

// File: rtl/mac_serial_pkg.sv
// Shared definitions for the serial multiply-accumulate datapath:
// default fixed-point format, saturation limits and FSM state encoding.
package mac_serial_pkg;

    // Default Q8.24 format used by the neuron datapath
    localparam int WIDTH_DEF = 32;
    localparam int FRAC_DEF  = 24;

    // Saturation limits for the default width
    localparam logic signed [WIDTH_DEF-1:0] SAT_MAX = {1'b0, {(WIDTH_DEF-1){1'b1}}};
    localparam logic signed [WIDTH_DEF-1:0] SAT_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

    // MAC controller states
    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    // Largest positive value representable in a given width
    function automatic logic [63:0] sat_max_of(input int width);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < 63; i++) begin
            if (i < width - 1) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/mult_fixed.sv
// Combinational signed fixed-point multiplier: full-width product, arithmetic
// shift right by FRAC (rounds toward minus infinity), then clamp to the
// WIDTH-bit signed range. o_ovf flags that the clamp was applied.
module mult_fixed
    import mac_serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_p,
    output logic             o_ovf
);

    localparam int PW = 2 * WIDTH;

    localparam logic [WIDTH-1:0] L_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] L_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [PW-1:0]    w_a_ext;
    logic signed [PW-1:0]    w_b_ext;
    logic signed [PW-1:0]    w_full;
    logic signed [PW-1:0]    w_shift;
    logic        [PW-WIDTH:0] w_hi;

    // Sign-extend both operands so the product is exact in PW bits
    assign w_a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_b_ext = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_full  = w_a_ext * w_b_ext;
    assign w_shift = w_full >>> FRAC;

    // Bits above the result sign bit must all match the sign, otherwise clamp
    assign w_hi = w_shift[PW-1:WIDTH-1];

    // Detect overflow of the shifted product and select the clamped result
    always_comb begin
        o_ovf = !((&w_hi) || !(|w_hi));
        o_p   = w_shift[WIDTH-1:0];
        if (o_ovf) begin
            o_p = w_shift[PW-1] ? L_MIN : L_MAX;
        end
    end

endmodule

// File: rtl/mac_serial.sv
// Serial multiply-accumulate stage: accepts N (x, w) terms over a
// valid/ready input, accumulates the saturated products with a saturating
// adder, then holds the dot product and sticky saturation flag on a
// valid/ready output until it is taken.
module mac_serial
    import mac_serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int N     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_w,
    input  logic             i_clr,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_sat
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [WIDTH-1:0] L_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] L_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_sat;

    logic             w_accept;
    logic             w_clr;
    logic             w_last;
    logic             w_take;
    logic [WIDTH-1:0] w_prod;
    logic             w_mul_ovf;
    logic [WIDTH:0]   w_sum_ext;
    logic             w_acc_ovf;
    logic [WIDTH-1:0] w_acc_next;

    // Handshake qualifiers decoded straight from the state register
    assign w_accept = i_valid && (r_state == S_ACC);
    assign w_clr    = i_clr   && (r_state == S_ACC);
    assign w_take   = i_ready && (r_state == S_OUT);
    assign w_last   = (r_cnt == CNT_LAST);

    mult_fixed #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mult (
        .i_a   (i_x),
        .i_b   (i_w),
        .o_p   (w_prod),
        .o_ovf (w_mul_ovf)
    );

    // Saturating accumulate: one guard bit catches signed overflow
    always_comb begin
        w_sum_ext  = {r_acc[WIDTH-1], r_acc} + {w_prod[WIDTH-1], w_prod};
        w_acc_ovf  = w_sum_ext[WIDTH] ^ w_sum_ext[WIDTH-1];
        w_acc_next = w_sum_ext[WIDTH-1:0];
        if (w_acc_ovf) begin
            w_acc_next = w_sum_ext[WIDTH] ? L_MIN : L_MAX;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; a clear suppresses the final transition
    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        case (r_state)
            S_ACC: begin
                o_ready = 1'b1;
                if (w_accept && !i_clr && w_last) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_state_next = S_ACC;
                end
            end
            default: begin
                w_state_next = S_ACC;
            end
        endcase
    end

    // Accumulator, term counter and sticky saturation flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_sat <= r_sat | w_mul_ovf | w_acc_ovf;
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end else if (w_take) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end
    end

    // Result is the accumulator itself, so it is stable while o_valid waits
    assign o_sum = r_acc;
    assign o_sat = r_sat;

endmodule

// File: tb/tb_mac_serial.sv
// Bench for mac_serial (WIDTH=32, FRAC=24, N=4): a table of hand-computed dot
// products, hand-written corner sequences (backpressure, bubbles, async reset,
// abort), and random dot products checked against an arithmetic model.
module tb_mac_serial;

    localparam logic [31:0] ONE  = 32'h0100_0000;
    localparam logic [31:0] TWO  = 32'h0200_0000;
    localparam logic [31:0] HALF = 32'h0080_0000;
    localparam logic [31:0] QTR  = 32'h0040_0000;
    localparam logic [31:0] NEG1 = 32'hFF00_0000;
    localparam logic [31:0] FIVE = 32'h0500_0000;
    localparam logic [31:0] P127 = 32'h7F00_0000;
    localparam logic [31:0] MINV = 32'h8000_0000;
    localparam logic [31:0] MAXV = 32'h7FFF_FFFF;

    typedef logic [31:0] quad_t [4];

    typedef struct {
        quad_t       x;
        quad_t       w;
        logic [31:0] sum;
        bit          sat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_x;
    logic [31:0] i_w;
    logic        i_clr;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_sum;
    logic        o_sat;

    int n_cmp = 0;
    int n_err = 0;

    mac_serial #(
        .WIDTH (32),
        .FRAC  (24),
        .N     (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_x     (i_x),
        .i_w     (i_w),
        .i_clr   (i_clr),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_sat   (o_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact products in 64-bit, floor shift, clamp, clamped running sum
    function automatic void model(input quad_t xs, input quad_t ws,
                                  output logic [31:0] s, output bit sat);
        longint acc;
        longint p;
        acc = 0;
        sat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p = longint'($signed(xs[i])) * longint'($signed(ws[i]));
            p = p >>> 24;
            if (p > 64'sd2147483647)       begin p = 64'sd2147483647;  sat = 1'b1; end
            else if (p < -64'sd2147483648) begin p = -64'sd2147483648; sat = 1'b1; end
            acc = acc + p;
            if (acc > 64'sd2147483647)       begin acc = 64'sd2147483647;  sat = 1'b1; end
            else if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; sat = 1'b1; end
        end
        s = acc[31:0];
    endfunction

    task automatic send_term(input logic [31:0] x, input logic [31:0] w,
                             input bit last, input string tag);
        chk1({tag, " o_ready before term"}, o_ready, 1'b1);
        i_valid = 1'b1;
        i_x     = x;
        i_w     = w;
        step();
        i_valid = 1'b0;
        i_x     = $urandom;
        i_w     = $urandom;
        chk1({tag, " o_valid after term"}, o_valid, last);
    endtask

    // Feed four terms (with gap idle cycles between), then check and drain the
    // result after stall cycles of backpressure carrying junk input terms.
    task automatic run_dot(input quad_t xs, input quad_t ws, input logic [31:0] exp_sum,
                           input bit exp_sat, input int gap, input int stall,
                           input bit clr_in_stall, input string tag);
        for (int i = 0; i < 4; i++) begin
            send_term(xs[i], ws[i], (i == 3), tag);
            if (i < 3) begin
                repeat (gap) begin
                    i_x = $urandom;
                    i_w = $urandom;
                    step();
                end
            end
        end
        chk({tag, " o_sum"}, o_sum, exp_sum);
        chk1({tag, " o_sat"}, o_sat, exp_sat);
        chk1({tag, " o_ready in result"}, o_ready, 1'b0);
        for (int s = 0; s < stall; s++) begin
            i_ready = 1'b0;
            i_valid = 1'b1;
            i_clr   = clr_in_stall;
            i_x     = $urandom;
            i_w     = $urandom;
            step();
            chk1({tag, " o_valid held"}, o_valid, 1'b1);
            chk({tag, " o_sum held"}, o_sum, exp_sum);
            chk1({tag, " o_sat held"}, o_sat, exp_sat);
        end
        i_valid = 1'b0;
        i_clr   = 1'b0;
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        chk1({tag, " o_ready after take"}, o_ready, 1'b1);
        chk1({tag, " o_valid after take"}, o_valid, 1'b0);
        chk({tag, " o_sum cleared"}, o_sum, 32'h0);
    endtask

    vec_t        tbl[11];
    quad_t       ones;
    quad_t       rx;
    quad_t       rw;
    logic [31:0] m_sum;
    bit          m_sat;

    initial begin
        tbl[0]  = '{x: '{ONE, HALF, NEG1, 32'h0}, w: '{TWO, HALF, ONE, FIVE}, sum: 32'h0140_0000, sat: 1'b0};
        tbl[1]  = '{x: '{P127, P127, P127, P127}, w: '{ONE, ONE, ONE, ONE}, sum: MAXV, sat: 1'b1};
        tbl[2]  = '{x: '{MINV, MINV, MINV, MINV}, w: '{ONE, ONE, ONE, ONE}, sum: MINV, sat: 1'b1};
        tbl[3]  = '{x: '{ONE, ONE, ONE, ONE}, w: '{ONE, ONE, ONE, ONE}, sum: 32'h0400_0000, sat: 1'b0};
        tbl[4]  = '{x: '{QTR, QTR, QTR, QTR}, w: '{ONE, ONE, ONE, ONE}, sum: 32'h0100_0000, sat: 1'b0};
        tbl[5]  = '{x: '{TWO, TWO, TWO, TWO}, w: '{ONE, ONE, ONE, ONE}, sum: 32'h0800_0000, sat: 1'b0};
        tbl[6]  = '{x: '{32'h4000_0000, 32'h0, 32'h0, 32'h0}, w: '{32'h0400_0000, 32'h0, 32'h0, 32'h0}, sum: MAXV, sat: 1'b1};
        tbl[7]  = '{x: '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, w: '{32'h1, 32'h1, 32'h1, 32'h1}, sum: 32'hFFFF_FFFC, sat: 1'b0};
        tbl[8]  = '{x: '{P127, P127, NEG1, NEG1}, w: '{ONE, ONE, ONE, ONE}, sum: 32'h7DFF_FFFF, sat: 1'b1};
        tbl[9]  = '{x: '{MINV, 32'h0, 32'h0, 32'h0}, w: '{MINV, 32'h0, 32'h0, 32'h0}, sum: MAXV, sat: 1'b1};
        tbl[10] = '{x: '{MINV, 32'h0, 32'h0, 32'h0}, w: '{MAXV, 32'h0, 32'h0, 32'h0}, sum: MINV, sat: 1'b1};
        ones    = '{ONE, ONE, ONE, ONE};

        rst     = 1'b1;
        i_valid = 1'b0;
        i_x     = '0;
        i_w     = '0;
        i_clr   = 1'b0;
        i_ready = 1'b0;
        #3;
        chk1("reset o_ready", o_ready, 1'b1);
        chk1("reset o_valid", o_valid, 1'b0);
        chk("reset o_sum", o_sum, 32'h0);
        chk1("reset o_sat", o_sat, 1'b0);
        step();
        rst = 1'b0;
        step();

        // Table: full-rate dot products, immediate drain
        for (int i = 0; i < 11; i++) begin
            run_dot(tbl[i].x, tbl[i].w, tbl[i].sum, tbl[i].sat, 0, 0, 1'b0, $sformatf("tbl%0d", i));
        end

        // Backpressure with junk terms and an ignored clear, then a fresh product
        run_dot(tbl[1].x, tbl[1].w, MAXV, 1'b1, 0, 3, 1'b1, "bp_sat");
        run_dot(ones, ones, 32'h0400_0000, 1'b0, 0, 0, 1'b0, "bp_next");

        // Bubbles between terms
        run_dot(tbl[0].x, tbl[0].w, 32'h0140_0000, 1'b0, 2, 0, 1'b0, "bubbles");

        // Asynchronous reset mid dot product, asserted between edges
        send_term(ONE, ONE, 1'b0, "rst_pre");
        send_term(ONE, ONE, 1'b0, "rst_pre");
        chk("rst_pre partial", o_sum, TWO);
        #2;
        rst = 1'b1;
        #1;
        chk1("async rst o_ready", o_ready, 1'b1);
        chk1("async rst o_valid", o_valid, 1'b0);
        chk("async rst o_sum", o_sum, 32'h0);
        #2;
        rst = 1'b0;
        step();
        run_dot(tbl[4].x, tbl[4].w, 32'h0100_0000, 1'b0, 0, 0, 1'b0, "after_rst");

        // Abort: clear wins over a simultaneous term on what would be the 4th
        send_term(ONE, ONE, 1'b0, "abort_pre");
        send_term(ONE, ONE, 1'b0, "abort_pre");
        send_term(ONE, ONE, 1'b0, "abort_pre");
        i_clr   = 1'b1;
        i_valid = 1'b1;
        i_x     = ONE;
        i_w     = ONE;
        step();
        i_clr   = 1'b0;
        i_valid = 1'b0;
        chk1("abort o_valid", o_valid, 1'b0);
        chk1("abort o_ready", o_ready, 1'b1);
        chk("abort o_sum", o_sum, 32'h0);
        run_dot(tbl[5].x, tbl[5].w, 32'h0800_0000, 1'b0, 0, 0, 1'b0, "after_abort");

        // Random dot products against the arithmetic model
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 4; i++) begin
                rx[i] = $urandom;
                rw[i] = $urandom;
                if (n % 3 != 0) begin
                    rx[i] = {{6{rx[i][31]}}, rx[i][31:6]};
                    rw[i] = {{6{rw[i][31]}}, rw[i][31:6]};
                end
            end
            model(rx, rw, m_sum, m_sat);
            run_dot(rx, rw, m_sum, m_sat, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
